// File: rtl/avs_accel_csr.sv
// avs_accel_csr: Avalon-MM CSR slave that owns the accelerator run FSM (GO -> START, BUSY until DONE).
// Optional feature macro: AVS_ACCEL_IRQ_EN (adds the IRQ port and a read/write CTRL.IRQ_EN bit).
// Ports:
//   CSI_CLOCK_CLK, CSI_CLOCK_RESET   single clock, synchronous active-high reset
//   AVS_AVALONSLAVE_*                Avalon-MM slave; writes take zero wait states,
//                                    reads take one wait cycle with registered READDATA
//   START                            one-cycle accelerator start pulse
//   DONE                             accelerator completion, sampled only while running
//   BUSY                             high while the run FSM is in RUN
//   ARGS                             flat argument bus, arg k at [k*DW +: DW]
//   IRQ                              level interrupt (only with AVS_ACCEL_IRQ_EN)
// Register map: 0 CTRL {IRQ_EN, GO}, 1 STATUS {ERR, DONE, BUSY}, 2..1+NUM_ARGS ARG[k].
module avs_accel_csr #(
    parameter int AVS_AVALONSLAVE_DATA_WIDTH    = 32,
    parameter int AVS_AVALONSLAVE_ADDRESS_WIDTH = 4,
    parameter int NUM_ARGS                      = 4
) (
    input  logic                                           CSI_CLOCK_CLK,
    input  logic                                           CSI_CLOCK_RESET,
    input  logic [AVS_AVALONSLAVE_ADDRESS_WIDTH-1:0]       AVS_AVALONSLAVE_ADDRESS,
    input  logic                                           AVS_AVALONSLAVE_READ,
    input  logic                                           AVS_AVALONSLAVE_WRITE,
    input  logic [AVS_AVALONSLAVE_DATA_WIDTH/8-1:0]        AVS_AVALONSLAVE_BYTEENABLE,
    input  logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]          AVS_AVALONSLAVE_WRITEDATA,
    output logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]          AVS_AVALONSLAVE_READDATA,
    output logic                                           AVS_AVALONSLAVE_WAITREQUEST,
    output logic                                           START,
    input  logic                                           DONE,
    output logic                                           BUSY,
    output logic [NUM_ARGS*AVS_AVALONSLAVE_DATA_WIDTH-1:0] ARGS
`ifdef AVS_ACCEL_IRQ_EN
    ,
    output logic                                           IRQ
`endif
);
    localparam int DW = AVS_AVALONSLAVE_DATA_WIDTH;
    localparam int AW = AVS_AVALONSLAVE_ADDRESS_WIDTH;
    localparam int BW = DW / 8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_n;
    logic               start_q;
    logic               done_q, done_n;
    logic               err_q, err_n;
    logic               rd_phase_q;
    logic               rd_first;
    logic               hit_ctrl, hit_stat, go;
    logic [DW-1:0]      rdata_q, rdata_n;
    logic [NUM_ARGS*DW-1:0] args_q, args_n;
`ifdef AVS_ACCEL_IRQ_EN
    logic               irq_en_q, irq_en_n;
    logic               irq_q;
`endif

    always_comb begin
        hit_ctrl = AVS_AVALONSLAVE_WRITE && AVS_AVALONSLAVE_ADDRESS == AW'(0);
        hit_stat = AVS_AVALONSLAVE_WRITE && AVS_AVALONSLAVE_ADDRESS == AW'(1);
        // GO only counts when its byte lane is enabled
        go       = hit_ctrl && AVS_AVALONSLAVE_BYTEENABLE[0] && AVS_AVALONSLAVE_WRITEDATA[0];
        state_n  = (state_q == IDLE) ? (go ? RUN : IDLE) : (DONE ? IDLE : RUN);
        // set events take priority over a same-cycle write-1-to-clear
        done_n   = (state_q == RUN && DONE) ||
                   (done_q && !(hit_stat && AVS_AVALONSLAVE_BYTEENABLE[0] && AVS_AVALONSLAVE_WRITEDATA[1]));
        err_n    = (state_q == RUN && go) ||
                   (err_q && !(hit_stat && AVS_AVALONSLAVE_BYTEENABLE[0] && AVS_AVALONSLAVE_WRITEDATA[2]));
`ifdef AVS_ACCEL_IRQ_EN
        irq_en_n = (hit_ctrl && AVS_AVALONSLAVE_BYTEENABLE[0]) ? AVS_AVALONSLAVE_WRITEDATA[1] : irq_en_q;
`endif
        args_n = args_q;
        for (int k = 0; k < NUM_ARGS; k++)
            for (int b = 0; b < BW; b++)
                if (AVS_AVALONSLAVE_WRITE && AVS_AVALONSLAVE_ADDRESS == AW'(k + 2) && AVS_AVALONSLAVE_BYTEENABLE[b])
                    args_n[k*DW + b*8 +: 8] = AVS_AVALONSLAVE_WRITEDATA[b*8 +: 8];
        // a write in the same cycle as a read drops the read
        rd_first = AVS_AVALONSLAVE_READ && !AVS_AVALONSLAVE_WRITE && !rd_phase_q;
        rdata_n  = '0;
        if (AVS_AVALONSLAVE_ADDRESS == AW'(0)) begin
`ifdef AVS_ACCEL_IRQ_EN
            rdata_n[1] = irq_en_q;
`endif
        end else if (AVS_AVALONSLAVE_ADDRESS == AW'(1)) begin
            rdata_n[2:0] = {err_q, done_q, state_q == RUN};
        end else begin
            for (int k = 0; k < NUM_ARGS; k++)
                if (AVS_AVALONSLAVE_ADDRESS == AW'(k + 2))
                    rdata_n = args_q[k*DW +: DW];
        end
    end

    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (CSI_CLOCK_RESET) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_phase_q <= 1'b0;
            rdata_q    <= '0;
            args_q     <= '0;
`ifdef AVS_ACCEL_IRQ_EN
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            start_q    <= state_q == IDLE && go;
            done_q     <= done_n;
            err_q      <= err_n;
            rd_phase_q <= rd_first;
            rdata_q    <= rd_first ? rdata_n : rdata_q;
            args_q     <= args_n;
`ifdef AVS_ACCEL_IRQ_EN
            irq_en_q   <= irq_en_n;
            irq_q      <= irq_en_q && (done_q || err_q);
`endif
        end
    end

    assign AVS_AVALONSLAVE_READDATA    = rdata_q;
    assign AVS_AVALONSLAVE_WAITREQUEST = rd_first;
    assign START                       = start_q;
    assign BUSY                        = state_q == RUN;
    assign ARGS                        = args_q;
`ifdef AVS_ACCEL_IRQ_EN
    assign IRQ                         = irq_q;
`endif
endmodule

// File: tb/tb_avs_accel_csr.sv
// tb_avs_accel_csr: scoreboard bench for avs_accel_csr (read data checked by a negedge monitor).
module tb_avs_accel_csr;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NA = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     addr = '0;
    logic              rd = 1'b0;
    logic              wr = 1'b0;
    logic [DW/8-1:0]   be = '0;
    logic [DW-1:0]     wdata = '0;
    logic [DW-1:0]     rdata;
    logic              waitreq;
    logic              start;
    logic              done = 1'b0;
    logic              busy;
    logic [NA*DW-1:0]  args;
`ifdef AVS_ACCEL_IRQ_EN
    logic              irq;
    localparam logic [31:0] CTRL_RB = 32'h2;
`else
    localparam logic [31:0] CTRL_RB = 32'h0;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    avs_accel_csr #(
        .AVS_AVALONSLAVE_DATA_WIDTH(DW),
        .AVS_AVALONSLAVE_ADDRESS_WIDTH(AW),
        .NUM_ARGS(NA)
    ) dut (
        .CSI_CLOCK_CLK(clk),
        .CSI_CLOCK_RESET(rst),
        .AVS_AVALONSLAVE_ADDRESS(addr),
        .AVS_AVALONSLAVE_READ(rd),
        .AVS_AVALONSLAVE_WRITE(wr),
        .AVS_AVALONSLAVE_BYTEENABLE(be),
        .AVS_AVALONSLAVE_WRITEDATA(wdata),
        .AVS_AVALONSLAVE_READDATA(rdata),
        .AVS_AVALONSLAVE_WAITREQUEST(waitreq),
        .START(start),
        .DONE(done),
        .BUSY(busy),
        .ARGS(args)
`ifdef AVS_ACCEL_IRQ_EN
        ,
        .IRQ(irq)
`endif
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // read completes when READ is held and WAITREQUEST is low
    always @(negedge clk) begin
        if (rd && !wr && !waitreq) begin
            if (exp_q.size() == 0)
                check("unexpected read completion", 128'(1), 128'(0));
            else
                check(name_q.pop_front(), 128'(rdata), 128'(exp_q.pop_front()));
        end
    end

    task automatic wr_reg(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
        @(posedge clk);
        #1 wr = 1'b1; addr = a; wdata = d; be = b;
        @(posedge clk);
        #1 wr = 1'b0; be = '0;
    endtask

    task automatic rd_reg(input logic [AW-1:0] a, input logic [31:0] e, input string nm);
        int n;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1 rd = 1'b1; addr = a;
        @(negedge clk);
        check({nm, " waitreq"}, 128'(waitreq), 128'(1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (waitreq && n < 4);
        check({nm, " wait cycles"}, 128'(n), 128'(1));
        @(posedge clk);
        #1 rd = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst readdata", 128'(rdata), 128'(0));
        check("rst waitreq", 128'(waitreq), 128'(0));
        check("rst start", 128'(start), 128'(0));
        check("rst busy", 128'(busy), 128'(0));
        check("rst args", 128'(args), 128'(0));
`ifdef AVS_ACCEL_IRQ_EN
        check("rst irq", 128'(irq), 128'(0));
`endif
        rst = 1'b0;
        for (int a = 0; a <= 2 + NA; a++)
            rd_reg(AW'(a), 32'h0, $sformatf("rst read %0d", a));

        wr_reg(4'd3, 32'hAABBCCDD, 4'b0101);
        rd_reg(4'd3, 32'h00BB00DD, "arg1 byteenable");
        check("args arg1", 128'(args[63:32]), 128'(32'h00BB00DD));
        wr_reg(4'd3, 32'h11223344, 4'b1010);
        rd_reg(4'd3, 32'h11BB33DD, "arg1 merge");
        wr_reg(4'd2, 32'h12345678, 4'hF);
        wr_reg(4'd5, 32'hDEADBEEF, 4'hF);
        wr_reg(4'd6, 32'hFFFFFFFF, 4'hF);
        check("args all", 128'(args), {32'hDEADBEEF, 32'h0, 32'h11BB33DD, 32'h12345678});
        rd_reg(4'd5, 32'hDEADBEEF, "arg3");
        rd_reg(4'd6, 32'h0, "unmapped 6");
        rd_reg(4'd15, 32'h0, "unmapped 15");

        wr_reg(4'd0, 32'h1, 4'b0000);
        @(negedge clk);
        check("go lane off start", 128'(start), 128'(0));
        check("go lane off busy", 128'(busy), 128'(0));
        wr_reg(4'd0, 32'hFFFFFFFE, 4'hF);
        rd_reg(4'd0, CTRL_RB, "ctrl readback");
        wr_reg(4'd0, 32'h0, 4'hF);

        wr_reg(4'd0, 32'h1, 4'hF);
        @(negedge clk);
        check("go start", 128'(start), 128'(1));
        check("go busy", 128'(busy), 128'(1));
        @(negedge clk);
        check("start one cycle", 128'(start), 128'(0));
        check("busy held", 128'(busy), 128'(1));
        repeat (8) @(posedge clk);
        pulse_done();
        @(negedge clk);
        check("done busy low", 128'(busy), 128'(0));
        rd_reg(4'd1, 32'h2, "status done");
        wr_reg(4'd1, 32'h2, 4'b1110);
        rd_reg(4'd1, 32'h2, "w1c lane off");
        wr_reg(4'd1, 32'h2, 4'hF);
        pulse_done();
        rd_reg(4'd1, 32'h0, "done ignored idle");

        wr_reg(4'd0, 32'h1, 4'hF);
        @(negedge clk);
        check("run2 start", 128'(start), 128'(1));
        wr_reg(4'd0, 32'h1, 4'hF);
        @(negedge clk);
        check("go busy no start", 128'(start), 128'(0));
        check("go busy still busy", 128'(busy), 128'(1));
        rd_reg(4'd1, 32'h5, "status err");
        wr_reg(4'd1, 32'h4, 4'hF);
        rd_reg(4'd1, 32'h1, "err cleared");
        pulse_done();
        @(negedge clk);
        check("run2 done busy", 128'(busy), 128'(0));
        rd_reg(4'd1, 32'h2, "run2 status");
        wr_reg(4'd1, 32'h2, 4'hF);

        @(posedge clk);
        #1 wr = 1'b1; rd = 1'b1; addr = 4'd4; wdata = 32'hCAFEF00D; be = 4'hF;
        @(negedge clk);
        check("rw no wait", 128'(waitreq), 128'(0));
        @(posedge clk);
        #1 wr = 1'b0; rd = 1'b0; be = '0;
        check("rw write done", 128'(args[95:64]), 128'(32'hCAFEF00D));
        rd_reg(4'd4, 32'hCAFEF00D, "arg2");

`ifdef AVS_ACCEL_IRQ_EN
        wr_reg(4'd0, 32'h3, 4'hF);
        @(negedge clk);
        check("irq before done", 128'(irq), 128'(0));
        repeat (3) @(posedge clk);
        pulse_done();
        @(negedge clk);
        @(negedge clk);
        check("irq after done", 128'(irq), 128'(1));
        wr_reg(4'd0, 32'h3, 4'hF);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1 wr = 1'b1; addr = 4'd1; wdata = 32'h2; be = 4'hF; done = 1'b1;
        @(posedge clk);
        #1 wr = 1'b0; be = '0; done = 1'b0;
        @(negedge clk);
        check("collide busy", 128'(busy), 128'(0));
        check("collide irq", 128'(irq), 128'(1));
        rd_reg(4'd1, 32'h2, "collide done kept");
        wr_reg(4'd1, 32'h2, 4'hF);
        @(negedge clk);
        check("irq drop lag", 128'(irq), 128'(1));
        @(negedge clk);
        check("irq dropped", 128'(irq), 128'(0));
`endif

        wr_reg(4'd0, 32'h3, 4'hF);
        @(negedge clk);
        check("pre-reset busy", 128'(busy), 128'(1));
        @(posedge clk);
        #1 rst = 1'b1; wr = 1'b1; addr = 4'd0; wdata = 32'h1; be = 4'hF;
        @(posedge clk);
        #1 rst = 1'b0; wr = 1'b0; be = '0;
        @(negedge clk);
        check("reset busy", 128'(busy), 128'(0));
        check("reset start", 128'(start), 128'(0));
        check("reset args", 128'(args), 128'(0));
`ifdef AVS_ACCEL_IRQ_EN
        check("reset irq", 128'(irq), 128'(0));
`endif
        pulse_done();
        rd_reg(4'd1, 32'h0, "status after reset");
        repeat (2) @(posedge clk);
        check("scoreboard drained", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/avs_accel_csr.md
# avs_accel_csr

Parametrised Avalon-MM slave control/status register file for the accelerators on the lab SoC, successor to the fixed four-register slave. Owns the accelerator run state machine: a CPU write to GO produces a single-cycle START, the block tracks BUSY until the accelerator raises DONE, then latches a sticky DONE flag and optionally raises an interrupt. Exports a configurable number of argument registers as a flat bus, supports byte enables, and returns read data with one registered wait cycle.

## Interface
- AVS_AVALONSLAVE_DATA_WIDTH, 32, data width; multiple of 8.
- AVS_AVALONSLAVE_ADDRESS_WIDTH, 4, word address width.
- NUM_ARGS, 4, argument registers; legal range 1 .. 2^ADDRESS_WIDTH − 2.
- CSI_CLOCK_CLK  in  1  single clock; everything is on its rising edge.
- CSI_CLOCK_RESET  in  1  reset, synchronous, active-high.
- AVS_AVALONSLAVE_ADDRESS  in  ADDRESS_WIDTH  word address.
- AVS_AVALONSLAVE_READ  in  1  read request.
- AVS_AVALONSLAVE_WRITE  in  1  write request.
- AVS_AVALONSLAVE_BYTEENABLE  in  DATA_WIDTH/8  per-byte write enable.
- AVS_AVALONSLAVE_WRITEDATA  in  DATA_WIDTH  write data.
- AVS_AVALONSLAVE_READDATA  out  DATA_WIDTH  registered read data.
- AVS_AVALONSLAVE_WAITREQUEST  out  1  stall; high for the first cycle of each read.
- START  out  1  one-cycle accelerator start pulse.
- DONE  in  1  accelerator completion; sampled only in RUN.
- BUSY  out  1  high while in RUN.
- ARGS  out  NUM_ARGS*DATA_WIDTH  argument registers; arg k at bits [k*DW +: DW].
- IRQ  out  1  interrupt, only with AVS_ACCEL_IRQ_EN.

## Operation
- Register map, by word address:
  - 0 CTRL: bit0 GO, write-1 action, always reads 0; bit1 IRQ_EN, read/write; all other bits read 0.
  - 1 STATUS: bit0 BUSY, read-only; bit1 DONE_STICKY, write-1-to-clear; bit2 ERR_STICKY, write-1-to-clear; other bits read 0.
  - 2 .. 1+NUM_ARGS ARG[k]: read/write, honours BYTEENABLE.
  - Any other address: reads return 0; writes are ignored.
- BYTEENABLE applies to every register: a W1C or GO bit acts only if its byte lane is enabled.
- Run FSM: states IDLE, RUN.
  - IDLE → RUN when a GO=1 write arrives; START = 1 in the following cycle only.
  - RUN → IDLE on the first cycle DONE = 1; DONE_STICKY is set that cycle.
  - DONE is ignored in IDLE.
  - GO=1 written while in RUN: no START, state unchanged, ERR_STICKY set.
- Same-cycle conflicts: a set event wins over a W1C clear of the same bit (DONE capture vs clear; ERR set vs clear).
- READ and WRITE asserted together: the write executes and the read is dropped (no wait cycle).
- ARGS are not frozen during RUN; the software contract is to leave them unchanged while BUSY.

## Timing
- Write: zero wait states; the register updates at the edge where WRITE is sampled.
- Read, cycle 0 (READ first seen): WAITREQUEST = 1; READDATA is captured from the addressed register.
- Read, cycle 1: WAITREQUEST = 0; READDATA is valid and held until the next read capture.
- The master holds READ and ADDRESS through the wait cycle. Back-to-back reads therefore take 2 cycles each.
- Latency from the GO write edge to START high: 1 cycle. BUSY rises in the same cycle as START.
- Latency from DONE high in RUN to BUSY low and DONE_STICKY high: 1 edge.
- Reset values: READDATA 0, WAITREQUEST 0, START 0, BUSY 0, ARGS 0, IRQ 0, IRQ_EN 0, sticky bits 0, FSM IDLE.
- Reset mid-operation (RUN or a pending read wait cycle) aborts immediately; the outputs take their reset values on the next edge and no START is emitted.

## Configuration
- Macro AVS_ACCEL_IRQ_EN.
- Defined: IRQ is registered and equals IRQ_EN & (DONE_STICKY | ERR_STICKY). It is level-sensitive and drops 1 cycle after the W1C write that clears the cause.
- Undefined: the IRQ port is absent and CTRL bit1 is read-only 0. All other behaviour is identical.

## Test plan
- Reset, then read addresses 0 .. 2+NUM_ARGS → all read 0; each read shows exactly one WAITREQUEST cycle.
- Write ARG[1] = 0xAABBCCDD with BYTEENABLE = 4'b0101 over prior value 0 → reads back 0x00BB00DD; ARGS[63:32] = 0x00BB00DD.
- Write CTRL = 0x1 → START high for exactly 1 cycle, BUSY = 1. Drive DONE after 10 cycles → BUSY = 0 and STATUS reads 0x2.
- Write GO while BUSY → no START; STATUS reads 0x5. Write STATUS = 0x4 → reads 0x1.
- With AVS_ACCEL_IRQ_EN: IRQ_EN = 1, complete a run → IRQ = 1. Write STATUS = 0x2 in the same cycle a new DONE arrives → DONE_STICKY stays 1 and IRQ stays 1.
- Assert reset during RUN → BUSY, START, and IRQ are 0 next cycle; a subsequent DONE pulse leaves STATUS = 0.
